// File: rtl/edge_detect_array.sv
// Multi-channel synchronised rising/falling edge detector with sticky flags and a saturating event counter.
// Define GLITCH_FILTER_EN to insert a per-channel FILTER_LEN-cycle stability filter ahead of detection.
module edge_detect_array #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int FILTER_LEN  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] pulse,
  output logic [WIDTH-1:0] sticky,
  output logic             any_sticky,
  output logic [CNT_W-1:0] evt_cnt
);

  // Extra headroom bits let a full-width popcount land on a saturated counter without wrapping.
  localparam int SUM_W = CNT_W + $clog2(WIDTH + 1);
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] det_lvl;
  logic [WIDTH-1:0] lvl_q;
  logic [WIDTH-1:0] pulse_next;
  logic [SUM_W-1:0] pop_cnt;
  logic [SUM_W-1:0] cnt_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  logic [FW-1:0]    flt_cnt [WIDTH];
  logic [WIDTH-1:0] flt_lvl;

  // The filtered level follows sync only after FILTER_LEN consecutive disagreeing cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flt_lvl <= '0;
      for (int i = 0; i < WIDTH; i++) flt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == flt_lvl[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == FLT_LAST) begin
          flt_lvl[i] <= sync[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign det_lvl = flt_lvl;
`else
  assign det_lvl = sync;

  if (FILTER_LEN < 2) begin : g_filter_len_below_min
  end
`endif

  assign pulse_next = (det_lvl & ~lvl_q & rise_en) | (~det_lvl & lvl_q & fall_en);

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < WIDTH; i++) pop_cnt = pop_cnt + SUM_W'(pulse[i]);
  end

  // A clear restarts from this cycle's pulses so coincident events are kept.
  always_comb begin
    cnt_sum = '0;
    if (cnt_clr) cnt_sum = pop_cnt;
    else         cnt_sum = SUM_W'(evt_cnt) + pop_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q   <= '0;
      pulse   <= '0;
      sticky  <= '0;
      evt_cnt <= '0;
    end else begin
      lvl_q   <= det_lvl;
      pulse   <= pulse_next;
      sticky  <= pulse_next | (sticky & ~clr);
      evt_cnt <= (cnt_sum > CNT_MAX) ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

  assign any_sticky = |sticky;

endmodule

// File: tb/tb_edge_detect_array.sv
// Directed bench for edge_detect_array: an 8-bit-counter instance and a 4-bit-counter instance share stimulus.
module tb_edge_detect_array;

`ifdef GLITCH_FILTER_EN
  localparam int FL = 4;
`else
  localparam int FL = 0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic [7:0] rise_en;
  logic [7:0] fall_en;
  logic [7:0] clr;
  logic       cnt_clr;

  logic [7:0] pulse_a, sticky_a, pulse_b, sticky_b;
  logic       any_a, any_b;
  logic [7:0] cnt_a;
  logic [3:0] cnt_b;

  int total = 0;
  int bad   = 0;

  edge_detect_array #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(8), .FILTER_LEN(4)) dut_a (
    .clk(clk), .reset(reset), .din(din), .rise_en(rise_en), .fall_en(fall_en),
    .clr(clr), .cnt_clr(cnt_clr), .pulse(pulse_a), .sticky(sticky_a),
    .any_sticky(any_a), .evt_cnt(cnt_a)
  );

  edge_detect_array #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(4), .FILTER_LEN(4)) dut_b (
    .clk(clk), .reset(reset), .din(din), .rise_en(rise_en), .fall_en(fall_en),
    .clr(clr), .cnt_clr(cnt_clr), .pulse(pulse_b), .sticky(sticky_b),
    .any_sticky(any_b), .evt_cnt(cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    din     = 8'h00;
    rise_en = 8'hFF;
    fall_en = 8'h00;
    clr     = 8'h00;
    cnt_clr = 1'b0;

    applyStimulus(2);
    checkOutput("rst_pulse", 32'(pulse_a), 32'h00);
    checkOutput("rst_sticky", 32'(sticky_a), 32'h00);
    checkOutput("rst_any", 32'(any_a), 32'h0);
    checkOutput("rst_cnt", 32'(cnt_a), 32'h00);
    reset = 1'b0;
    applyStimulus(2);

    // single rising edge on channel 3
    din = 8'h08;
    applyStimulus(2 + FL);
    checkOutput("rise_early", 32'(pulse_a), 32'h00);
    applyStimulus(1);
    checkOutput("rise_pulse", 32'(pulse_a), 32'h08);
    checkOutput("rise_sticky", 32'(sticky_a), 32'h08);
    checkOutput("rise_any", 32'(any_a), 32'h1);
    checkOutput("rise_cnt_lag", 32'(cnt_a), 32'h00);
    applyStimulus(1);
    checkOutput("rise_pulse_end", 32'(pulse_a), 32'h00);
    checkOutput("rise_cnt", 32'(cnt_a), 32'h01);

    // falling edge with fall detection disabled
    din = 8'h00;
    applyStimulus(3 + FL);
    checkOutput("fall_off_pulse", 32'(pulse_a), 32'h00);
    applyStimulus(1);
    checkOutput("fall_off_cnt", 32'(cnt_a), 32'h01);

    // clr held across a new pulse: set wins, then clears
    din = 8'h08;
    applyStimulus(2 + FL);
    clr = 8'h08;
    applyStimulus(1);
    checkOutput("clr_set_pulse", 32'(pulse_a), 32'h08);
    checkOutput("clr_set_sticky", 32'(sticky_a), 32'h08);
    applyStimulus(1);
    checkOutput("clr_sticky", 32'(sticky_a), 32'h00);
    checkOutput("clr_any", 32'(any_a), 32'h0);
    checkOutput("clr_cnt", 32'(cnt_a), 32'h02);
    clr = 8'h00;

    // both edges enabled, full-width transitions
    rise_en = 8'hFF;
    fall_en = 8'hFF;
    din = 8'h00;
    applyStimulus(5 + FL);
    checkOutput("fall3_cnt", 32'(cnt_a), 32'h03);
    cnt_clr = 1'b1;
    applyStimulus(1);
    cnt_clr = 1'b0;
    checkOutput("cntclr_zero", 32'(cnt_a), 32'h00);
    din = 8'hFF;
    applyStimulus(3 + FL);
    checkOutput("all_rise", 32'(pulse_a), 32'hFF);
    applyStimulus(7);
    din = 8'h00;
    applyStimulus(3 + FL);
    checkOutput("all_fall", 32'(pulse_a), 32'hFF);
    applyStimulus(1);
    checkOutput("all_fall_end", 32'(pulse_a), 32'h00);
    checkOutput("all_cnt16", 32'(cnt_a), 32'h10);
    checkOutput("all_cnt_sat4", 32'(cnt_b), 32'hF);

    // 20 single-channel edges saturate the 4-bit counter
    cnt_clr = 1'b1;
    applyStimulus(1);
    cnt_clr = 1'b0;
    for (int t = 0; t < 20; t++) begin
      din[0] = ~din[0];
      applyStimulus(FL + 1);
    end
    applyStimulus(5 + FL);
    checkOutput("tog_cnt20", 32'(cnt_a), 32'h14);
    checkOutput("tog_cnt_sat", 32'(cnt_b), 32'hF);

    // clear coincident with a two-channel pulse keeps those events
    din = 8'h05;
    applyStimulus(3 + FL);
    checkOutput("p05_pulse", 32'(pulse_a), 32'h05);
    cnt_clr = 1'b1;
    applyStimulus(1);
    cnt_clr = 1'b0;
    checkOutput("p05_cnt_a", 32'(cnt_a), 32'h02);
    checkOutput("p05_cnt_b", 32'(cnt_b), 32'h2);

    // input high through reset release yields one rise pulse
    rise_en = 8'h01;
    fall_en = 8'h00;
    din = 8'h01;
    reset = 1'b1;
    applyStimulus(2);
    checkOutput("hold_rst_cnt", 32'(cnt_a), 32'h00);
    checkOutput("hold_rst_sticky", 32'(sticky_a), 32'h00);
    reset = 1'b0;
    applyStimulus(2 + FL);
    checkOutput("hold_early", 32'(pulse_a), 32'h00);
    applyStimulus(1);
    checkOutput("hold_pulse", 32'(pulse_a), 32'h01);
    applyStimulus(1);
    checkOutput("hold_pulse_end", 32'(pulse_a), 32'h00);
    checkOutput("hold_cnt", 32'(cnt_a), 32'h01);

    // reset while an edge is in the synchroniser
    rise_en = 8'hFF;
    din = 8'h03;
    applyStimulus(1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_sticky", 32'(sticky_a), 32'h00);
    checkOutput("mid_rst_cnt", 32'(cnt_a), 32'h00);
    din = 8'h00;
    applyStimulus(2);
    reset = 1'b0;
    applyStimulus(4 + FL);
    checkOutput("mid_pulse", 32'(pulse_a), 32'h00);
    checkOutput("mid_sticky", 32'(sticky_a), 32'h00);
    checkOutput("mid_any", 32'(any_a), 32'h0);
    checkOutput("mid_cnt", 32'(cnt_a), 32'h00);

`ifdef GLITCH_FILTER_EN
    // glitch filtering: 3-cycle pulse suppressed, 4-cycle pulse passes
    rise_en = 8'h01;
    fall_en = 8'h00;
    din = 8'h01;
    applyStimulus(3);
    din = 8'h00;
    applyStimulus(12);
    checkOutput("glitch3_sticky", 32'(sticky_a), 32'h00);
    checkOutput("glitch3_cnt", 32'(cnt_a), 32'h00);
    din = 8'h01;
    applyStimulus(4);
    din = 8'h00;
    applyStimulus(FL - 2);
    checkOutput("glitch4_early", 32'(pulse_a), 32'h00);
    applyStimulus(1);
    checkOutput("glitch4_pulse", 32'(pulse_a), 32'h01);
    applyStimulus(12);
    checkOutput("glitch4_cnt", 32'(cnt_a), 32'h01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_detect_array.md
Name: edge_detect_array

Overview:
Multi-channel, parametrised successor to the single-bit positive-edge detector. It synchronises WIDTH asynchronous or debounced inputs and detects rising and/or falling edges per channel under runtime enables. Each detected edge emits a one-cycle pulse, sets a sticky flag that software clears, and feeds a saturating global event counter. The block sits between the debouncer/input pads and control logic or interrupt sources.

Parameters:
WIDTH, 8, number of independent input channels (>=1)
SYNC_STAGES, 2, flops in each input synchroniser chain (>=1)
CNT_W, 8, width of the saturating event counter (>=2)
FILTER_LEN, 4, stable cycles required by the glitch filter (>=2; used only when GLITCH_FILTER_EN is defined)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
din  in  WIDTH  channel inputs, may be asynchronous to clk
rise_en  in  WIDTH  per-channel enable for 0->1 detection
fall_en  in  WIDTH  per-channel enable for 1->0 detection
clr  in  WIDTH  per-channel sticky clear, write-1-to-clear, sampled on clk
cnt_clr  in  1  event counter clear, sampled on clk
pulse  out  WIDTH  registered one-cycle edge strobe per channel
sticky  out  WIDTH  registered latched edge flag per channel
any_sticky  out  1  OR-reduction of sticky
evt_cnt  out  CNT_W  saturating count of all pulses across all channels

Behaviour:
- Reset (async, active-high): sync chains, previous-level register lvl_q, pulse, sticky and evt_cnt all 0. any_sticky is therefore 0. Reset mid-operation discards in-flight edges; there is no partial pulse.
- Clock and reset: clock clk; reset is asynchronous and active-high.
- Per channel i: sync[i] is the last stage of the SYNC_STAGES chain. lvl_q[i] <= sync[i] every cycle.
- Detection, registered: pulse[i] <= (sync[i] & ~lvl_q[i] & rise_en[i]) | (~sync[i] & lvl_q[i] & fall_en[i]).
- Latency: a din change meeting setup before edge 1 reaches sync at edge SYNC_STAGES. pulse is high for exactly one cycle after edge SYNC_STAGES+1.
- Both enables high: each transition produces one pulse. Both enables low: no pulse, but lvl_q still tracks the input.
- Enables are sampled at the detection edge. Toggling an enable does not create a pulse.
- Because the reset level is 0, a din held at 1 through reset release yields one rise pulse SYNC_STAGES+1 cycles after release, if rise_en is set. This is intentional: it matches legacy PED behaviour.
- Input toggling every cycle: every synchronised transition is reported, so pulses may appear on consecutive cycles.
- Sticky: sticky[i] <= pulse_next[i] | (sticky[i] & ~clr[i]). sticky rises on the same edge as pulse. Simultaneous set and clr: set wins, so the flag stays 1. clr on an already-clear flag has no effect.
- Counter, one edge after pulse: evt_cnt <= min(evt_cnt + popcount(pulse), 2^CNT_W-1). The popcount may exceed 1 when several channels pulse in one cycle. Addition is performed at CNT_W+clog2(WIDTH+1) bits, then saturated, with no wrap-around. Once saturated, evt_cnt holds at all-ones until cleared.
- cnt_clr: evt_cnt <= popcount(pulse) that cycle, so events coincident with a clear are not lost.

Optional Feature:
GLITCH_FILTER_EN:
- Defined: a per-channel counter is inserted between sync and detection. The filtered level flips only after sync differs from it for FILTER_LEN consecutive cycles; the counter restarts on any match. Detection uses the filtered level in place of sync, adding FILTER_LEN cycles of latency. Pulses shorter than FILTER_LEN cycles are suppressed entirely. Filter counters and levels reset to 0.
- Undefined: no filter logic is generated and FILTER_LEN is ignored.

Test Plan:
- WIDTH=8, SYNC_STAGES=2, rise_en=FF, fall_en=00. Raise din[3] 0->1 -> pulse=08 for one cycle, 3 cycles later; sticky[3]=1; any_sticky=1; evt_cnt=1 one cycle later. Lowering din[3] -> no pulse.
- fall_en=FF, rise_en=FF. din 00->FF->00 at 10-cycle spacing -> two pulses of FF; evt_cnt=16.
- Hold clr[3]=1 across the cycle pulse[3] fires -> sticky[3] stays 1. Assert clr[3] the next cycle -> sticky[3]=0, any_sticky=0.
- CNT_W=4: 20 single-channel edges -> evt_cnt saturates at 15. cnt_clr asserted on a cycle with pulse=05 -> evt_cnt=2.
- din=01 held through reset, rise_en=01 -> pulse[0] once at cycle 3 after release. Assert reset while an edge is in the sync chain -> no pulse, all outputs 0.
- With GLITCH_FILTER_EN, FILTER_LEN=4: 3-cycle high glitch on din[0] -> no pulse. 4-cycle high -> one rise pulse, FILTER_LEN cycles later than the unfiltered build.
